// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and timer width for the traffic phase scheduler.
// Pedestrian walk support is enabled in the top level by defining TRAFFIC_PED_WALK_EN.
package traffic_pkg;

    localparam int TIMER_W = 7;

    localparam logic [2:0] PH_G0  = 3'd0;
    localparam logic [2:0] PH_Y0  = 3'd1;
    localparam logic [2:0] PH_AR0 = 3'd2;
    localparam logic [2:0] PH_G1  = 3'd3;
    localparam logic [2:0] PH_Y1  = 3'd4;
    localparam logic [2:0] PH_AR1 = 3'd5;
    localparam logic [2:0] PH_WK  = 3'd6;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef struct packed {
        logic [2:0] tf0;
        logic [2:0] tf1;
        logic       walk;
    } lamps_t;

    // Anything that is not a known green/yellow phase shows all red.
    function automatic lamps_t phase_lamps(input logic [2:0] ph);
        lamps_t l;
        l.tf0  = LAMP_RED;
        l.tf1  = LAMP_RED;
        l.walk = 1'b0;
        case (ph)
            PH_G0:   l.tf0  = LAMP_GRN;
            PH_Y0:   l.tf0  = LAMP_YEL;
            PH_G1:   l.tf1  = LAMP_GRN;
            PH_Y1:   l.tf1  = LAMP_YEL;
            PH_WK:   l.walk = 1'b1;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// One-second tick generator: TICK is high for the single CLK in which the
// enabled counter sits at CLK_DIV-1; the counter then wraps to zero.
module traffic_tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);

    localparam int              CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             at_max;

    assign at_max = (cnt_reg == CNT_MAX);
    assign TICK   = EN && at_max;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_reg <= '0;
        end else if (EN) begin
            cnt_reg <= at_max ? '0 : cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-direction traffic light phase scheduler with per-phase second countdown.
// Define TRAFFIC_PED_WALK_EN to build the pedestrian request latch and walk phase.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int CLK_DIV  = 50_000_000,
    parameter int T_GREEN0 = 9,
    parameter int T_GREEN1 = 12,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [1:0]         PED_REQ,
    output logic [2:0]         TF0,
    output logic [2:0]         TF1,
    output logic               WALK,
    output logic [TIMER_W-1:0] TIMER,
    output logic [2:0]         PHASE
);

    logic               tick;
    logic [2:0]         phase_reg;
    logic [2:0]         phase_next;
    logic [TIMER_W-1:0] timer_reg;
    logic [TIMER_W-1:0] timer_next;
    logic               ped_pending;
    logic               wk_back_to_g1;
    logic               wk_entry;
    lamps_t             lamps;

    traffic_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .TICK(tick)
    );

    function automatic logic [TIMER_W-1:0] phase_dur(input logic [2:0] ph);
        case (ph)
            PH_G0:        return TIMER_W'(T_GREEN0);
            PH_G1:        return TIMER_W'(T_GREEN1);
            PH_Y0, PH_Y1: return TIMER_W'(T_YELLOW);
            PH_WK:        return TIMER_W'(T_WALK);
            default:      return TIMER_W'(T_ALLRED);
        endcase
    endfunction

`ifdef TRAFFIC_PED_WALK_EN
    localparam logic [2:0] PH_MAX_LEGAL = PH_WK;

    logic ped_latch_reg;
    logic ped_latch_next;
    logic wk_from_ar0_reg;
    logic wk_from_ar0_next;

    // A request arriving on the WK entry cycle wins over the clear.
    always_comb begin
        ped_latch_next   = (wk_entry ? 1'b0 : ped_latch_reg) | (|PED_REQ);
        wk_from_ar0_next = wk_from_ar0_reg;
        if (wk_entry) begin
            wk_from_ar0_next = (phase_reg == PH_AR0);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ped_latch_reg   <= 1'b0;
            wk_from_ar0_reg <= 1'b0;
        end else begin
            ped_latch_reg   <= ped_latch_next;
            wk_from_ar0_reg <= wk_from_ar0_next;
        end
    end

    assign ped_pending   = ped_latch_reg;
    assign wk_back_to_g1 = wk_from_ar0_reg;
    assign WALK          = lamps.walk;
`else
    localparam logic [2:0] PH_MAX_LEGAL = PH_AR1;

    logic unused_ped;

    assign unused_ped    = ^{PED_REQ, wk_entry, lamps.walk};
    assign ped_pending   = 1'b0;
    assign wk_back_to_g1 = 1'b0;
    assign WALK          = 1'b0;
`endif

    // Illegal codes recover to AR0 regardless of EN so the lamps never stay undefined.
    always_comb begin
        phase_next = phase_reg;
        timer_next = timer_reg;
        wk_entry   = 1'b0;
        if (phase_reg > PH_MAX_LEGAL) begin
            phase_next = PH_AR0;
            timer_next = phase_dur(PH_AR0);
        end else if (tick) begin
            if (timer_reg > TIMER_W'(1)) begin
                timer_next = timer_reg - TIMER_W'(1);
            end else begin
                case (phase_reg)
                    PH_G0:   phase_next = PH_Y0;
                    PH_Y0:   phase_next = PH_AR0;
                    PH_AR0: begin
                        phase_next = ped_pending ? PH_WK : PH_G1;
                        wk_entry   = ped_pending;
                    end
                    PH_G1:   phase_next = PH_Y1;
                    PH_Y1:   phase_next = PH_AR1;
                    PH_AR1: begin
                        phase_next = ped_pending ? PH_WK : PH_G0;
                        wk_entry   = ped_pending;
                    end
                    PH_WK:   phase_next = wk_back_to_g1 ? PH_G1 : PH_G0;
                    default: phase_next = PH_AR0;
                endcase
                timer_next = phase_dur(phase_next);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_reg <= PH_AR1;
            timer_reg <= TIMER_W'(T_ALLRED);
        end else begin
            phase_reg <= phase_next;
            timer_reg <= timer_next;
        end
    end

    assign lamps = phase_lamps(phase_reg);
    assign TF0   = lamps.tf0;
    assign TF1   = lamps.tf1;
    assign TIMER = timer_reg;
    assign PHASE = phase_reg;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched at CLK_DIV=4; expectations follow the
// build of TRAFFIC_PED_WALK_EN (walk path when defined, requests ignored otherwise).
module tb_traffic_phase_sched;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic [1:0] PED_REQ = 2'b00;
    logic [2:0] TF0;
    logic [2:0] TF1;
    logic       WALK;
    logic [6:0] TIMER;
    logic [2:0] PHASE;

    int n_checks = 0;
    int n_fail = 0;

    traffic_phase_sched #(
        .CLK_DIV (4),
        .T_GREEN0(9),
        .T_GREEN1(12),
        .T_YELLOW(3),
        .T_ALLRED(1),
        .T_WALK  (8)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .PED_REQ(PED_REQ),
        .TF0    (TF0),
        .TF1    (TF1),
        .WALK   (WALK),
        .TIMER  (TIMER),
        .PHASE  (PHASE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_tf0(input int ph);
        case (ph)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_tf1(input int ph);
        case (ph)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic int exp_timer(input int ph);
        case (ph)
            0:       return 9;
            1:       return 3;
            3:       return 12;
            4:       return 3;
            6:       return 8;
            default: return 1;
        endcase
    endfunction

    // One clock, sampled 1 time unit after the edge, with the conflict check.
    task automatic step();
        @(posedge CLK);
        #1;
        check("no_conflict", {31'd0, (TF0[1:0] != 2'b00) && (TF1[1:0] != 2'b00)}, 0);
`ifndef TRAFFIC_PED_WALK_EN
        check("walk_off", {31'd0, WALK}, 0);
`endif
    endtask

    task automatic run_phase(input string tag, input int cur, input int nxt, input int exp_cyc);
        int cyc;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (PHASE == 3'(cur) && cyc < 400);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_phase"}, {29'd0, PHASE}, nxt);
        check({tag, "_tf0"}, {29'd0, TF0}, {29'd0, exp_tf0(nxt)});
        check({tag, "_tf1"}, {29'd0, TF1}, {29'd0, exp_tf1(nxt)});
        check({tag, "_timer"}, {25'd0, TIMER}, exp_timer(nxt));
        check({tag, "_walk"}, {31'd0, WALK}, (nxt == 6) ? 1 : 0);
    endtask

    task automatic wait_for(input string tag, input int ph, input int tval);
        int cyc;
        cyc = 0;
        while (!(PHASE == 3'(ph) && TIMER == 7'(tval)) && cyc < 200) begin
            step();
            cyc++;
        end
        check({tag, "_reached"}, {31'd0, (PHASE == 3'(ph) && TIMER == 7'(tval))}, 1);
    endtask

    initial begin
        int cyc;

        // Reset state while RST is held
        #12;
        check("rst_phase", {29'd0, PHASE}, 5);
        check("rst_timer", {25'd0, TIMER}, 1);
        check("rst_tf0", {29'd0, TF0}, 3'b100);
        check("rst_tf1", {29'd0, TF1}, 3'b100);
        check("rst_walk", {31'd0, WALK}, 0);

        @(posedge CLK);
        #1;
        RST = 1'b0;
        EN  = 1'b1;
`ifndef TRAFFIC_PED_WALK_EN
        PED_REQ = 2'b11;
`endif

        // One full free-running cycle
        run_phase("ar1_g0", 5, 0, 4);
        run_phase("g0_y0", 0, 1, 36);
        run_phase("y0_ar0", 1, 2, 12);
        run_phase("ar0_g1", 2, 3, 4);
        run_phase("g1_y1", 3, 4, 48);
        run_phase("y1_ar1", 4, 5, 12);
        run_phase("ar1_g0b", 5, 0, 4);

        // Pedestrian request pulse early in G0
`ifdef TRAFFIC_PED_WALK_EN
        PED_REQ = 2'b01;
        step();
        PED_REQ = 2'b00;
        run_phase("p_g0_y0", 0, 1, 35);
        run_phase("p_y0_ar0", 1, 2, 12);
        run_phase("p_ar0_wk", 2, 6, 4);
        run_phase("p_wk_g1", 6, 3, 32);
`else
        step();
        run_phase("p_g0_y0", 0, 1, 35);
        run_phase("p_y0_ar0", 1, 2, 12);
        run_phase("p_ar0_g1", 2, 3, 4);
`endif

        // Freeze mid-G1 with two cycles of the current second already counted
        wait_for("g1_t5", 3, 5);
        step();
        step();
        EN = 1'b0;
        repeat (20) step();
        check("frz_timer", {25'd0, TIMER}, 5);
        check("frz_phase", {29'd0, PHASE}, 3);
        check("frz_tf0", {29'd0, TF0}, 3'b100);
        check("frz_tf1", {29'd0, TF1}, 3'b001);
        EN = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (TIMER == 7'd5 && cyc < 50);
        check("resume_cycles", cyc, 2);
        check("resume_timer", {25'd0, TIMER}, 4);
        run_phase("r_g1_y1", 3, 4, 16);
        run_phase("r_y1_ar1", 4, 5, 12);
        run_phase("r_ar1_g0", 5, 0, 4);

        // Reset in Y0 with TIMER=2 and a pending request
        wait_for("y0_t2", 1, 2);
`ifdef TRAFFIC_PED_WALK_EN
        PED_REQ = 2'b01;
        step();
        PED_REQ = 2'b00;
`else
        step();
`endif
        RST = 1'b1;
        #1;
        check("mid_rst_phase", {29'd0, PHASE}, 5);
        check("mid_rst_timer", {25'd0, TIMER}, 1);
        check("mid_rst_tf0", {29'd0, TF0}, 3'b100);
        check("mid_rst_tf1", {29'd0, TF1}, 3'b100);
        check("mid_rst_walk", {31'd0, WALK}, 0);
        step();
        RST = 1'b0;
        run_phase("post_rst_ar1_g0", 5, 0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
